// File: rtl/out_ep_router.sv
// ---------------------------------------------------------------------------
// out_ep_router : steers the SIE OUT stream to one of N_EP endpoint FIFOs and
//                 tracks the expected DATA0/DATA1 toggle of each endpoint.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module out_ep_router #(
  parameter int N_EP = 2
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            clk_gate_i,
  input  logic            out_token_i,
  input  logic [3:0]      out_ep_i,
  input  logic [7:0]      out_data_i,
  input  logic            out_valid_i,
  input  logic            out_err_i,
  input  logic            out_ready_i,
  output logic            out_nak_o,
  output logic            out_stall_o,
  input  logic [N_EP-1:0] ep_enable_i,
  input  logic [N_EP-1:0] toggle_clear_i,
  output logic [N_EP-1:0] out_toggle_o,
  output logic [7:0]      fifo_out_data_o,
  output logic [N_EP-1:0] fifo_out_valid_o,
  output logic [N_EP-1:0] fifo_out_err_o,
  output logic [N_EP-1:0] fifo_out_ready_o,
  input  logic [N_EP-1:0] fifo_out_nak_i,
  output logic            busy_o,
  output logic [3:0]      sel_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ROUTE   = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [3:0] EP_MAX     = 4'(N_EP);

  logic [1:0]      state_q, state_d;
  logic [3:0]      sel_q, sel_d;
  logic [N_EP-1:0] toggle_q, toggle_d;

  // Widened copies let a 4-bit index address any endpoint without range checks.
  logic [15:0]     en_ext, nak_ext, sel_oh;
  logic            ep_hit, eop, sel_nak;

  assign en_ext  = 16'(ep_enable_i);
  assign nak_ext = 16'(fifo_out_nak_i);
  assign sel_oh  = 16'd1 << sel_q;
  assign sel_nak = nak_ext[sel_q];
  assign eop     = out_ready_i & ~out_valid_i;
  assign ep_hit  = (out_ep_i != 4'd0) && (out_ep_i <= EP_MAX) && en_ext[out_ep_i - 4'd1];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      sel_q    <= 4'd0;
      toggle_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      toggle_q <= toggle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    toggle_d = toggle_q;
    if (clk_gate_i) begin
      // A token always restarts decoding, even when the previous packet lacked EOP.
      if (out_token_i) begin
        state_d = ep_hit ? ST_ROUTE : ST_DISCARD;
        sel_d   = ep_hit ? (out_ep_i - 4'd1) : 4'd0;
      end else if (eop && state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        sel_d   = 4'd0;
        if (state_q == ST_ROUTE && !out_err_i && !sel_nak)
          toggle_d = toggle_q ^ sel_oh[N_EP-1:0];
      end
      if (state_q != ST_IDLE && state_q != ST_ROUTE && state_q != ST_DISCARD)
        state_d = ST_IDLE;
      toggle_d = toggle_d & ~toggle_clear_i;
    end
  end

  always_comb begin
    fifo_out_valid_o = '0;
    fifo_out_err_o   = '0;
    fifo_out_ready_o = '0;
    out_nak_o        = 1'b0;
    out_stall_o      = 1'b0;
    case (state_q)
      ST_ROUTE: begin
        out_nak_o = sel_nak;
        if (out_token_i) begin
          // Error-terminate the unfinished packet so the FIFO rolls it back.
          fifo_out_err_o   = sel_oh[N_EP-1:0];
          fifo_out_ready_o = sel_oh[N_EP-1:0];
        end else begin
          fifo_out_valid_o = out_valid_i ? sel_oh[N_EP-1:0] : '0;
          fifo_out_err_o   = out_err_i   ? sel_oh[N_EP-1:0] : '0;
          fifo_out_ready_o = out_ready_i ? sel_oh[N_EP-1:0] : '0;
        end
      end
      ST_DISCARD: out_stall_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o          = (state_q != ST_IDLE);
  assign sel_o           = busy_o ? sel_q : 4'd0;
  assign out_toggle_o    = toggle_q;
  assign fifo_out_data_o = out_data_i;

endmodule

`default_nettype wire

// File: tb/tb_out_ep_router.sv
// ---------------------------------------------------------------------------
// tb_out_ep_router : directed and randomized checks of out_ep_router.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_out_ep_router;
  localparam int N_EP = 2;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            gate = 1'b0;
  logic            token = 1'b0;
  logic [3:0]      ep = 4'd0;
  logic [7:0]      data = 8'd0;
  logic            valid = 1'b0, err = 1'b0, ready = 1'b0;
  logic            nak_o, stall_o, busy_o;
  logic [N_EP-1:0] en = '1, clr = '0, tog_o, fv_o, fe_o, fr_o, fnak = '0;
  logic [7:0]      fdata_o;
  logic [3:0]      sel_o;

  int checks = 0;
  int failures = 0;

  // Reference: -1 = no packet, -2 = packet being discarded, k = routed to FIFO k.
  int              m_dest = -1;
  logic [N_EP-1:0] m_tog = '0;

  out_ep_router #(.N_EP(N_EP)) dut (
    .clk_i(clk), .rstn_i(rstn), .clk_gate_i(gate), .out_token_i(token),
    .out_ep_i(ep), .out_data_i(data), .out_valid_i(valid), .out_err_i(err),
    .out_ready_i(ready), .out_nak_o(nak_o), .out_stall_o(stall_o),
    .ep_enable_i(en), .toggle_clear_i(clr), .out_toggle_o(tog_o),
    .fifo_out_data_o(fdata_o), .fifo_out_valid_o(fv_o), .fifo_out_err_o(fe_o),
    .fifo_out_ready_o(fr_o), .fifo_out_nak_i(fnak), .busy_o(busy_o), .sel_o(sel_o)
  );

  always #5 clk = ~clk;

  function automatic void model_update();
    int e = int'(ep);
    if (token) begin
      if (e >= 1 && e <= N_EP && en[e-1]) m_dest = e - 1;
      else m_dest = -2;
    end else if (ready && !valid && m_dest != -1) begin
      if (m_dest >= 0 && !err && !fnak[m_dest]) m_tog[m_dest] = ~m_tog[m_dest];
      m_dest = -1;
    end
    m_tog = m_tog & ~clr;
  endfunction

  task automatic drive(input bit t, input logic [3:0] e, input bit v, input bit er, input bit r);
    @(negedge clk);
    token = t; ep = e; data = 8'($urandom); valid = v; err = er; ready = r; gate = 1'b1;
    #1;
  endtask

  task automatic commit();
    model_update();
    @(posedge clk);
    #1;
    gate = 1'b0; token = 1'b0; valid = 1'b0; err = 1'b0; ready = 1'b0; clr = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    checks++;
    if ({fv_o, fe_o, fr_o, nak_o, stall_o, busy_o, tog_o, sel_o} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", {fv_o, fe_o, fr_o, nak_o, stall_o, busy_o, tog_o, sel_o});
    end
    @(negedge clk);
    rstn = 1'b1;
    m_dest = -1; m_tog = '0;
  endtask

  task automatic test_route_basic();
    en = 2'b11; fnak = '0;
    drive(1, 4'd2, 0, 0, 0); commit();
    checks++;
    if (sel_o !== 4'd1 || busy_o !== 1'b1) begin
      failures++; $display("FAIL route_sel got sel=%0d busy=%b want sel=1 busy=1", sel_o, busy_o);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'd0, 1, 0, 1);
      checks++;
      if (fv_o !== 2'b10 || fr_o !== 2'b10 || fe_o !== 2'b00 || fdata_o !== data) begin
        failures++; $display("FAIL route_byte%0d got v=%b r=%b e=%b d=%h want v=10 r=10 e=00 d=%h", i, fv_o, fr_o, fe_o, fdata_o, data);
      end
      commit();
    end
    drive(0, 4'd0, 0, 0, 1);
    checks++;
    if (fv_o !== 2'b00 || fr_o !== 2'b10) begin
      failures++; $display("FAIL route_eop got v=%b r=%b want v=00 r=10", fv_o, fr_o);
    end
    commit();
    checks++;
    if (tog_o !== 2'b10 || busy_o !== 1'b0) begin
      failures++; $display("FAIL route_toggle got tog=%b busy=%b want tog=10 busy=0", tog_o, busy_o);
    end
  endtask

  task automatic test_nak();
    drive(1, 4'd1, 0, 0, 0); commit();
    fnak = 2'b01;
    for (int i = 0; i < 2; i++) begin
      drive(0, 4'd0, 1, 0, 1);
      checks++;
      if (nak_o !== 1'b1 || fv_o !== 2'b01) begin
        failures++; $display("FAIL nak_byte%0d got nak=%b v=%b want nak=1 v=01", i, nak_o, fv_o);
      end
      commit();
    end
    drive(0, 4'd0, 0, 0, 1); commit();
    fnak = '0;
    checks++;
    if (tog_o !== 2'b10 || busy_o !== 1'b0) begin
      failures++; $display("FAIL nak_toggle got tog=%b busy=%b want tog=10 busy=0", tog_o, busy_o);
    end
  endtask

  task automatic test_discard();
    logic [3:0] eps [2] = '{4'd3, 4'd0};
    foreach (eps[k]) begin
      drive(1, eps[k], 0, 0, 0); commit();
      drive(0, 4'd0, 1, 0, 1);
      checks++;
      if (stall_o !== 1'b1 || busy_o !== 1'b1 || nak_o !== 1'b0 || {fv_o, fe_o, fr_o} !== '0) begin
        failures++; $display("FAIL discard_ep%0d got stall=%b busy=%b nak=%b f=%b want stall=1 busy=1 nak=0 f=0", eps[k], stall_o, busy_o, nak_o, {fv_o, fe_o, fr_o});
      end
      commit();
      drive(0, 4'd0, 0, 0, 1); commit();
      checks++;
      if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
        failures++; $display("FAIL discard_exit_ep%0d got busy=%b stall=%b want 0 0", eps[k], busy_o, stall_o);
      end
    end
  endtask

  task automatic test_missing_eop();
    drive(1, 4'd1, 0, 0, 0); commit();
    repeat (2) begin drive(0, 4'd0, 1, 0, 1); commit(); end
    drive(1, 4'd2, 0, 0, 0);
    checks++;
    if (fe_o !== 2'b01 || fr_o !== 2'b01 || fv_o !== 2'b00) begin
      failures++; $display("FAIL rollback got e=%b r=%b v=%b want e=01 r=01 v=00", fe_o, fr_o, fv_o);
    end
    commit();
    checks++;
    if (sel_o !== 4'd1 || tog_o !== 2'b10) begin
      failures++; $display("FAIL rollback_next got sel=%0d tog=%b want sel=1 tog=10", sel_o, tog_o);
    end
    drive(0, 4'd0, 1, 0, 1);
    checks++;
    if (fv_o !== 2'b10) begin
      failures++; $display("FAIL rollback_route got v=%b want 10", fv_o);
    end
    commit();
    drive(0, 4'd0, 0, 0, 1); commit();
    checks++;
    if (tog_o !== 2'b00) begin
      failures++; $display("FAIL rollback_toggle got tog=%b want 00", tog_o);
    end
  endtask

  task automatic test_clear_and_reset();
    drive(1, 4'd1, 0, 0, 0); commit();
    drive(0, 4'd0, 1, 0, 1); commit();
    clr = 2'b01;
    drive(0, 4'd0, 0, 0, 1); commit();
    checks++;
    if (tog_o !== 2'b00) begin
      failures++; $display("FAIL clear_override got tog=%b want 00", tog_o);
    end
    drive(1, 4'd2, 0, 0, 0); commit();
    drive(0, 4'd0, 0, 0, 1); commit();
    drive(1, 4'd1, 0, 0, 0); commit();
    drive(0, 4'd0, 1, 0, 1); commit();
    checks++;
    if (tog_o !== 2'b10 || busy_o !== 1'b1) begin
      failures++; $display("FAIL pre_reset got tog=%b busy=%b want tog=10 busy=1", tog_o, busy_o);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || tog_o !== 2'b00 || sel_o !== 4'd0) begin
      failures++; $display("FAIL mid_reset got busy=%b tog=%b sel=%0d want 0 00 0", busy_o, tog_o, sel_o);
    end
    @(negedge clk);
    rstn = 1'b1;
    m_dest = -1; m_tog = '0;
    drive(0, 4'd0, 1, 0, 1);
    checks++;
    if ({fv_o, fr_o} !== '0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL post_reset got v=%b r=%b busy=%b want 0 0 0", fv_o, fr_o, busy_o);
    end
    commit();
  endtask

  task automatic test_random();
    logic [3*N_EP+3+N_EP+7:0] got, want;
    logic [N_EP-1:0] oh, ev, ee, er;
    bit en_nak, en_stall;
    for (int it = 0; it < 300; it++) begin
      int act = $urandom_range(0, 9);
      fnak = N_EP'($urandom);
      clr  = ($urandom_range(0, 7) == 0) ? N_EP'($urandom) : '0;
      if (act <= 1) begin
        en = N_EP'($urandom);
        drive(1, 4'($urandom_range(0, N_EP + 1)), 0, 0, 0);
      end else if (act <= 6) begin
        drive(0, 4'd0, 1, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
      end else if (act <= 8) begin
        drive(0, 4'd0, 0, $urandom_range(0, 3) == 0, 1);
      end else begin
        drive(0, 4'd0, 0, 0, 0);
      end
      ev = '0; ee = '0; er = '0; en_nak = 0; en_stall = (m_dest == -2);
      if (m_dest >= 0) begin
        oh = N_EP'(1) << m_dest;
        en_nak = fnak[m_dest];
        if (token) begin ee = oh; er = oh; end
        else begin ev = valid ? oh : '0; ee = err ? oh : '0; er = ready ? oh : '0; end
      end
      want = {ev, ee, er, en_nak, en_stall, m_dest != -1, m_tog, data};
      got  = {fv_o, fe_o, fr_o, nak_o, stall_o, busy_o, tog_o, fdata_o};
      checks++;
      if (got !== want) begin
        failures++; $display("FAIL random_step%0d got=%h want=%h", it, got, want);
      end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_route_basic();
    test_nak();
    test_discard();
    test_missing_eop();
    test_clear_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/out_ep_router.md
OUT_EP_ROUTER -- requirements
Module: out_ep_router

Interface
REQ-001 Parameter N_EP, default 2: number of OUT endpoints served, mapped to USB endpoints 1..N_EP, range 1..15.
REQ-002 Port clk_i  input  1  12MHz*BIT_SAMPLES clock; single clock domain.
REQ-003 Port rstn_i  input  1  asynchronous active-low reset.
REQ-004 Port clk_gate_i  input  1  one-in-BIT_SAMPLES enable; all registers update only when high.
REQ-005 Port out_token_i  input  1  one-gate-period pulse: OUT token for this device decoded.
REQ-006 Port out_ep_i  input  4  endpoint number; valid with out_token_i.
REQ-007 Port out_data_i  input  8  SIE OUT byte.
REQ-008 Ports out_valid_i, out_err_i, out_ready_i  input  1 each  SIE OUT handshake, same semantics as the per-endpoint FIFO OUT interface.
REQ-009 Port out_nak_o  output  1  NAK status returned to SIE.
REQ-010 Port out_stall_o  output  1  high while the current packet targets an unmapped or disabled endpoint.
REQ-011 Port ep_enable_i  input  N_EP  bit k enables endpoint k+1.
REQ-012 Port toggle_clear_i  input  N_EP  bit k clears data toggle of endpoint k+1.
REQ-013 Port out_toggle_o  output  N_EP  expected DATA PID per endpoint (0=DATA0, 1=DATA1).
REQ-014 Port fifo_out_data_o  output  8  out_data_i broadcast to all FIFOs.
REQ-015 Ports fifo_out_valid_o, fifo_out_err_o, fifo_out_ready_o  output  N_EP each  per-FIFO handshake.
REQ-016 Port fifo_out_nak_i  input  N_EP  per-FIFO out_nak_o.
REQ-017 Ports busy_o  output  1 (state != IDLE); sel_o  output  4 (selected FIFO index, 0 when IDLE).

Function
REQ-018 FSM states IDLE, ROUTE, DISCARD; registered sel_q selects FIFO index.
REQ-019 IDLE, clk_gate_i & out_token_i: if 1 <= out_ep_i <= N_EP and ep_enable_i[out_ep_i-1] -> sel_q = out_ep_i-1, ROUTE; else -> DISCARD.
REQ-020 ROUTE: fifo_out_valid_o/err_o/ready_o[sel_q] = out_valid_i/out_err_i/out_ready_i combinationally; all other bits 0.
REQ-021 ROUTE: out_nak_o = fifo_out_nak_i[sel_q]; out_stall_o = 0.
REQ-022 ROUTE, clk_gate_i & out_ready_i & ~out_valid_i (EOP or error) -> IDLE.
REQ-023 At that ROUTE exit, toggle_q[sel_q] inverts only if ~out_err_i & ~fifo_out_nak_i[sel_q]; otherwise unchanged.
REQ-024 DISCARD: all fifo_* handshake outputs 0; out_stall_o = 1; out_nak_o = 0; data bytes dropped; clk_gate_i & out_ready_i & ~out_valid_i -> IDLE.
REQ-025 IDLE: all fifo_* handshake outputs 0; out_nak_o = 0; out_stall_o = 0.
REQ-026 out_token_i in ROUTE (missing EOP): that gate cycle drive fifo_out_err_o[sel_q] = fifo_out_ready_o[sel_q] = 1, valid 0 (FIFO rollback); no toggle change; new token then decoded as in REQ-019 same cycle.
REQ-027 out_token_i in DISCARD: no FIFO activity; token decoded as in REQ-019.
REQ-028 ep_enable_i change mid-packet: ignored until next token.
REQ-029 toggle_clear_i[k] with clk_gate_i: toggle_q[k] = 0; overrides simultaneous REQ-023 inversion.
REQ-030 out_toggle_o = toggle_q; fifo_out_data_o = out_data_i at all times.
REQ-031 out_ep_i = 0 (control) or > N_EP always -> DISCARD.

Reset
REQ-032 rstn_i low: state IDLE, sel_q 0, toggle_q all 0; hence out_nak_o 0, out_stall_o 0, busy_o 0, fifo_* handshakes 0.
REQ-033 Reset mid-packet: FSM returns IDLE immediately, no forwarding until next token.

Verification
REQ-034 N_EP=2, ep_enable=2'b11, token ep=2, 3 bytes, EOP -> only fifo bit1 strobes 3 valids + EOP; out_toggle_o=2'b10.
REQ-035 Token ep=1, fifo_out_nak_i[0]=1 during packet, EOP -> out_nak_o=1 through packet; out_toggle_o[0] unchanged.
REQ-036 Token ep=3 (N_EP=2), then ep=0 -> DISCARD each time, out_stall_o=1, fifo_* all 0, back to IDLE on EOP.
REQ-037 Token ep=1, 2 bytes, new token ep=2 without EOP -> one err+ready pulse on fifo bit0, then ep2 routed; toggle[0] unchanged.
REQ-038 toggle_clear_i[0]=1 coinciding with good EOP on ep1 -> out_toggle_o[0]=0; rstn_i low mid-ROUTE -> busy_o=0, out_toggle_o=0.
